// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
//
// Purpose: bundles the program-memory read bus, the redirect strobe and the
// decode-side valid/ready handshake of the instruction fetch unit.
//
// Signals:
//   pm_addr, pm_read_request     fetch unit -> memory   read request
//   pm_req_ready                 memory -> fetch unit   request accepted
//   pm_read_valid, pm_read_data  memory -> fetch unit   in-order read return
//   redirect_valid, redirect_pc  core -> fetch unit     branch/jump redirect
//   instr_valid, instr_data,
//   instr_pc                     fetch unit -> decode   head instruction
//   instr_ready                  decode -> fetch unit   head consumed
//
// Modports: master = fetch unit side, slave = memory/core/decode side.
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]  pm_addr;
    logic                   pm_read_request;
    logic                   pm_req_ready;
    logic                   pm_read_valid;
    logic [INSTR_WIDTH-1:0] pm_read_data;
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr_data;
    logic [ADDR_WIDTH-1:0]  instr_pc;

    modport master (
        output pm_addr, pm_read_request,
        input  pm_req_ready, pm_read_valid, pm_read_data,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  pm_addr, pm_read_request,
        output pm_req_ready, pm_read_valid, pm_read_data,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose: CPU front end. Issues program-memory reads from an internal PC,
// tracks in-flight reads with a credit scheme so the prefetch FIFO can never
// overflow, buffers returned instructions in order and hands them to decode
// over valid/ready. A redirect flushes the FIFO, retargets the PC and marks
// every read still in flight as stale so its response is dropped.
//
// Ports:
//   clk_in        system clock
//   rst_in        asynchronous active-low reset
//   bus           instr_fetch_unit_if.master (memory, redirect, decode)
//   stall_cycles  cycles with no instruction available to decode
//
// Optional feature: define FETCH_STALL_COUNTER_EN to build the saturating
// 32-bit decode-starvation counter; otherwise stall_cycles is tied to 0.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH      = 16,
    parameter int                    INSTR_WIDTH     = 16,
    parameter int                    FIFO_DEPTH      = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    instr_fetch_unit_if.master   bus,
    output logic [31:0]          stall_cycles
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [OUT_W-1:0] MAXOUT_C = OUT_W'(MAX_OUTSTANDING);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    // Address of the oldest in-flight read that will not be discarded. Reads
    // issued since the last redirect are consecutive, so the head of the
    // PC-tag queue is fully described by this one register.
    logic [ADDR_WIDTH-1:0] tag_pc_q, tag_pc_d;
    logic [OUT_W-1:0]      outstanding_q, outstanding_d;
    logic [OUT_W-1:0]      discard_q, discard_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;

    logic [INSTR_WIDTH-1:0] entry_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  entry_pc   [FIFO_DEPTH];

    logic [CNT_W:0] in_use;
    logic           issue_ok;
    logic           accept;
    logic           resp_stale;
    logic           resp_live;
    logic           fifo_full;
    logic           push;
    logic           pop;
    logic           resp_dec;

    // FIFO slots plus reads in flight; every in-flight read owns a slot.
    assign in_use     = {1'b0, count_q} + (CNT_W + 1)'(outstanding_q);
    assign issue_ok   = rst_in && !bus.redirect_valid &&
                        (outstanding_q < MAXOUT_C) && (in_use < DEPTH_W);
    assign accept     = issue_ok && bus.pm_req_ready;
    assign resp_stale = (discard_q != '0);
    assign resp_live  = bus.pm_read_valid && !resp_stale;
    assign fifo_full  = (count_q == DEPTH_C);
    assign push       = resp_live && !bus.redirect_valid && !fifo_full;
    assign pop        = (count_q != '0) && bus.instr_ready;
    assign resp_dec   = bus.pm_read_valid && (outstanding_q != '0);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        tag_pc_d      = tag_pc_q;
        discard_d     = discard_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q + OUT_W'(accept) - OUT_W'(resp_dec);

        if (bus.redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old
            // path; a response arriving this cycle is dropped either way.
            fetch_pc_d = bus.redirect_pc;
            tag_pc_d   = bus.redirect_pc;
            discard_d  = outstanding_d;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
            end
            if (resp_live) begin
                tag_pc_d = tag_pc_q + ADDR_WIDTH'(1);
            end
            if (bus.pm_read_valid && resp_stale) begin
                discard_d = discard_q - OUT_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            fetch_pc_q    <= RESET_PC;
            tag_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            tag_pc_q      <= tag_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Prefetch FIFO storage. Entries reset to zero so the head reads 0/0
    // straight out of reset.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [INSTR_WIDTH-1:0] data_q;
            logic [ADDR_WIDTH-1:0]  pc_q;

            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    data_q <= '0;
                    pc_q   <= '0;
                end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    data_q <= bus.pm_read_data;
                    pc_q   <= tag_pc_q;
                end
            end

            assign entry_data[gi] = data_q;
            assign entry_pc[gi]   = pc_q;
        end
    endgenerate

    assign bus.pm_read_request = issue_ok;
    assign bus.pm_addr         = fetch_pc_q;
    assign bus.instr_valid     = (count_q != '0);
    assign bus.instr_data      = entry_data[rd_ptr_q];
    assign bus.instr_pc        = entry_pc[rd_ptr_q];

    // The credit scheme reserves a slot for every live read, so a live
    // response into a full FIFO means the memory broke the protocol.
    assert property (@(posedge clk_in) disable iff (!rst_in)
        !(resp_live && !bus.redirect_valid && fifo_full));

`ifdef FETCH_STALL_COUNTER_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((count_q == '0) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int AW      = 16;
    localparam int IW      = 16;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] stall_cycles;

    instr_fetch_unit_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

    instr_fetch_unit #(
        .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .FIFO_DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(16'h0000)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .bus          (bus),
        .stall_cycles (stall_cycles)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: decode-visible queue plus in-flight reads with a stale flag.
    typedef struct { logic [AW-1:0] pc; bit stale; } infl_t;
    typedef struct { logic [AW-1:0] pc; logic [IW-1:0] data; } ent_t;
    infl_t         inflight[$];
    ent_t          exp_fifo[$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] mem_q[$];   // memory side: addresses accepted, awaiting return

    bit            last_req, last_acc, last_valid;
    logic [AW-1:0] last_addr, last_pc;
    logic [IW-1:0] last_data;

    typedef struct {
        bit rdy; bit ir; bit redir; logic [AW-1:0] rpc;
        bit e_req; logic [AW-1:0] e_addr; bit e_valid; logic [AW-1:0] e_pc;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [IW-1:0] memf(input logic [AW-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        bus.pm_req_ready = 1'b0; bus.pm_read_valid = 1'b0; bus.pm_read_data = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;
        #1;
        check("rst_req",   bus.pm_read_request, 0);
        check("rst_addr",  bus.pm_addr, 0);
        check("rst_valid", bus.instr_valid, 0);
        check("rst_data",  bus.instr_data, 0);
        check("rst_pc",    bus.instr_pc, 0);
        check("rst_stall", stall_cycles, 0);
        inflight.delete(); exp_fifo.delete(); mem_q.delete();
        m_pc = '0;
        @(posedge clk_in); @(negedge clk_in);
        @(posedge clk_in); @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    // One clock cycle: drive inputs, check against the model, advance model and memory.
    task automatic tick(input bit rdy, input bit ir, input bit redir,
                        input logic [AW-1:0] rpc, input bit resp_en);
        bit    exp_req, resp, popd;
        infl_t f;
        bus.pm_req_ready   = rdy;
        bus.instr_ready    = ir;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        resp = resp_en && (mem_q.size() > 0);
        bus.pm_read_valid = resp;
        bus.pm_read_data  = resp ? memf(mem_q[0]) : IW'($urandom);
        #1;
        exp_req = !redir && (inflight.size() < MAX_OUT) &&
                  ((exp_fifo.size() + inflight.size()) < DEPTH);
        check("model_req",   bus.pm_read_request, exp_req);
        check("model_addr",  bus.pm_addr, m_pc);
        check("model_valid", bus.instr_valid, exp_fifo.size() != 0);
        if (exp_fifo.size() != 0) begin
            check("model_pc",   bus.instr_pc,   exp_fifo[0].pc);
            check("model_data", bus.instr_data, exp_fifo[0].data);
        end
        last_req   = bus.pm_read_request;
        last_addr  = bus.pm_addr;
        last_acc   = bus.pm_read_request && rdy;
        last_valid = bus.instr_valid;
        last_pc    = bus.instr_pc;
        last_data  = bus.instr_data;

        popd = (exp_fifo.size() != 0) && ir;
        if (popd) void'(exp_fifo.pop_front());
        if (resp && inflight.size() > 0) begin
            f = inflight.pop_front();
            if (!f.stale && !redir) exp_fifo.push_back('{f.pc, memf(f.pc)});
        end
        if (last_acc) begin
            inflight.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 1'b1;
        end
        if (redir) begin
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            exp_fifo.delete();
            m_pc = rpc;
        end
        if (resp) void'(mem_q.pop_front());
        if (last_acc) mem_q.push_back(bus.pm_addr);
        @(posedge clk_in); @(negedge clk_in);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc_cnt;
        bit  found;
        logic [31:0] exp_stall;

        // Directed steady flow then redirect with a response arriving the same cycle.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0000};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h0000};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 16'h0001};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0004, 1'b1, 16'h0002};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h0000};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0101, 1'b0, 16'h0000};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0102, 1'b1, 16'h0100};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(vecs[i].rdy, vecs[i].ir, vecs[i].redir, vecs[i].rpc, 1'b1);
            check($sformatf("vec%0d_req", i),   last_req,   vecs[i].e_req);
            check($sformatf("vec%0d_addr", i),  last_addr,  vecs[i].e_addr);
            check($sformatf("vec%0d_valid", i), last_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_pc", i),   last_pc,   vecs[i].e_pc);
                check($sformatf("vec%0d_data", i), last_data, memf(vecs[i].e_pc));
            end
        end

        // Decode stalled: credits cap total issue at FIFO_DEPTH.
        do_reset();
        acc_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
            if (last_acc) acc_cnt++;
        end
        check("full_issue_count", acc_cnt, DEPTH);
        check("full_req_low", last_req, 0);
        check("full_head_pc", last_pc, 16'h0000);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            tick(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
            if (last_acc) begin
                found = 1'b1;
                check("resume_addr", last_addr, 16'h0004);
            end
        end
        check("resume_found", found, 1);

        // Memory back-pressure: request and address held.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
            check($sformatf("hold%0d_req", i),  last_req, 1);
            check($sformatf("hold%0d_addr", i), last_addr, 16'h0000);
        end
        tick(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        check("hold_accept_addr", last_addr, 16'h0000);
        check("hold_accept", last_acc, 1);

        // Redirect with two reads outstanding: both stale responses dropped.
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        check("redir_max_out_req", last_req, 0);
        tick(1'b1, 1'b1, 1'b1, 16'h0100, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
            if (last_valid) begin
                found = 1'b1;
                check("redir_first_pc", last_pc, 16'h0100);
                check("redir_first_data", last_data, memf(16'h0100));
            end
        end
        check("redir_found", found, 1);

        // PC wrap.
        do_reset();
        tick(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        check("wrap_acc0", last_acc, 1);
        check("wrap_addr0", last_addr, 16'hFFFF);
        tick(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        check("wrap_acc1", last_acc, 1);
        check("wrap_addr1", last_addr, 16'h0000);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);

        // Stall counter over five empty cycles after reset.
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
`ifdef FETCH_STALL_COUNTER_EN
        exp_stall = 32'd5;
`else
        exp_stall = 32'd0;
`endif
        check("stall_cycles", stall_cycles, exp_stall);

        // Randomised traffic against the model, with one reset mid-stream.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] rpc;
            rpc = ($urandom_range(0, 7) == 0) ? 16'hFFFE : AW'($urandom);
            if (i == 1500) do_reset();
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0, rpc, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
